// File: rtl/dma_ci_sequencer_if.sv
// Descriptor, CI and completion signals of the DMA CI sequencer.
interface dma_ci_sequencer_if #(
    parameter int unsigned fifoDepthLog2 = 2
) ();
    logic                     descValid;
    logic                     descReady;
    logic [31:0]              descBusAddr;
    logic [8:0]               descMemAddr;
    logic [9:0]               descBlockSize;
    logic [7:0]               descBurstSize;
    logic                     descDirIn;

    logic                     ciStart;
    logic [7:0]               ciN;
    logic [31:0]              ciValueA;
    logic [31:0]              ciValueB;
    logic                     ciDone;
    logic [31:0]              ciResult;

    logic                     cmplValid;
    logic                     cmplError;
    logic                     cmplTimeout;
    logic                     seqBusy;
    logic [fifoDepthLog2:0]   fifoCount;

    // Sequencer side: accepts descriptors, owns the CI port, reports completions.
    modport master (
        input  descValid, descBusAddr, descMemAddr, descBlockSize, descBurstSize, descDirIn,
        output descReady,
        output ciStart, ciN, ciValueA, ciValueB,
        input  ciDone, ciResult,
        output cmplValid, cmplError, cmplTimeout, seqBusy, fifoCount
    );

    // Environment side: descriptor source, DMA CI unit and completion sink.
    modport slave (
        output descValid, descBusAddr, descMemAddr, descBlockSize, descBurstSize, descDirIn,
        input  descReady,
        input  ciStart, ciN, ciValueA, ciValueB,
        output ciDone, ciResult,
        input  cmplValid, cmplError, cmplTimeout, seqBusy, fifoCount
    );
endinterface

// File: rtl/dma_ci_sequencer.sv
// Runs queued DMA descriptors through the DMA CI unit: programs the transfer,
// kicks it, polls status until idle (or poll limit) and reports one completion each.
module dma_ci_sequencer #(
    parameter logic [7:0]  customId      = 8'h00,
    parameter int unsigned fifoDepthLog2 = 2,
    parameter int unsigned pollGap       = 4,
    parameter logic [15:0] maxPolls      = 16'd4096
) (
    input  logic               clock,
    input  logic               reset,
    dma_ci_sequencer_if.master bus
);

    localparam int unsigned DEPTH = 1 << fifoDepthLog2;
    localparam int unsigned PTR_W = (fifoDepthLog2 > 0) ? fifoDepthLog2 : 1;
    localparam int unsigned CNT_W = fifoDepthLog2 + 1;
    localparam int unsigned GAP_W = (pollGap > 0) ? $clog2(pollGap + 1) : 1;

    typedef struct packed {
        logic [31:0] bus_addr;
        logic [8:0]  mem_addr;
        logic [9:0]  block_size;
        logic [7:0]  burst_size;
        logic        dir_in;
    } desc_t;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_BUS, S_CFG_MEM, S_CFG_SIZE, S_CFG_BURST,
        S_KICK, S_GAP, S_POLL, S_CMPL
    } state_e;

    state_e             state_q, state_d;
    desc_t              cur_q, cur_d;
    desc_t              fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [15:0]        poll_cnt_q, poll_cnt_d;
    logic               ci_start_q, ci_start_d;
    logic [7:0]         ci_n_q, ci_n_d;
    logic [31:0]        ci_value_a_q, ci_value_a_d;
    logic [31:0]        ci_value_b_q, ci_value_b_d;
    logic               cmpl_valid_q, cmpl_valid_d;
    logic               cmpl_error_q, cmpl_error_d;
    logic               cmpl_timeout_q, cmpl_timeout_d;
    logic               desc_ready_q, desc_ready_d;
    logic               seq_busy_q, seq_busy_d;

    logic               push;
    logic               pop;
    logic               launch;
    desc_t              desc_in;
    logic               unused_result_bits;

    assign desc_in = '{
        bus_addr:   bus.descBusAddr,
        mem_addr:   bus.descMemAddr,
        block_size: bus.descBlockSize,
        burst_size: bus.descBurstSize,
        dir_in:     bus.descDirIn
    };
    assign push               = bus.descValid & desc_ready_q;
    assign unused_result_bits = ^bus.ciResult[31:2];

    // Descriptor storage; data needs no reset, occupancy is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= desc_in;
        end
    end

    // Sequencer next state, CI op launch and completion flags.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        gap_cnt_d      = gap_cnt_q;
        poll_cnt_d     = poll_cnt_q;
        launch         = 1'b0;
        pop            = 1'b0;
        cmpl_valid_d   = 1'b0;
        cmpl_error_d   = cmpl_error_q;
        cmpl_timeout_d = cmpl_timeout_q;
        ci_value_a_d   = '0;
        ci_value_b_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    cur_d = fifo_mem_q[rd_ptr_q];
                    if (cur_d.block_size == '0) begin
                        state_d        = S_CMPL;
                        cmpl_valid_d   = 1'b1;
                        cmpl_error_d   = 1'b0;
                        cmpl_timeout_d = 1'b0;
                    end else begin
                        state_d = S_CFG_BUS;
                        launch  = 1'b1;
                    end
                end
            end
            S_CFG_BUS: if (bus.ciDone) begin
                state_d = S_CFG_MEM;
                launch  = 1'b1;
            end
            S_CFG_MEM: if (bus.ciDone) begin
                state_d = S_CFG_SIZE;
                launch  = 1'b1;
            end
            S_CFG_SIZE: if (bus.ciDone) begin
                state_d = S_CFG_BURST;
                launch  = 1'b1;
            end
            S_CFG_BURST: if (bus.ciDone) begin
                state_d = S_KICK;
                launch  = 1'b1;
            end
            S_KICK: if (bus.ciDone) begin
                poll_cnt_d = '0;
                if (pollGap == 0) begin
                    state_d = S_POLL;
                    launch  = 1'b1;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_W'(pollGap);
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = S_POLL;
                    launch  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_POLL: if (bus.ciDone) begin
                if (!bus.ciResult[0]) begin
                    state_d        = S_CMPL;
                    cmpl_valid_d   = 1'b1;
                    cmpl_error_d   = bus.ciResult[1];
                    cmpl_timeout_d = 1'b0;
                end else if (poll_cnt_q == maxPolls - 16'd1) begin
                    state_d        = S_CMPL;
                    cmpl_valid_d   = 1'b1;
                    cmpl_error_d   = bus.ciResult[1];
                    cmpl_timeout_d = 1'b1;
                end else begin
                    poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
                    if (pollGap == 0) begin
                        launch = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_W'(pollGap);
                    end
                end
            end
            S_CMPL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Operands of the op starting next cycle, zero when nothing starts.
        ci_start_d = launch;
        ci_n_d     = launch ? customId : 8'h00;
        if (launch) begin
            case (state_d)
                S_CFG_BUS: begin
                    ci_value_a_d = 32'h0000_0600;
                    ci_value_b_d = cur_d.bus_addr;
                end
                S_CFG_MEM: begin
                    ci_value_a_d = 32'h0000_0A00;
                    ci_value_b_d = {23'd0, cur_d.mem_addr};
                end
                S_CFG_SIZE: begin
                    ci_value_a_d = 32'h0000_0E00;
                    ci_value_b_d = {22'd0, cur_d.block_size};
                end
                S_CFG_BURST: begin
                    ci_value_a_d = 32'h0000_1200;
                    ci_value_b_d = {24'd0, cur_d.burst_size};
                end
                S_KICK: begin
                    ci_value_a_d = 32'h0000_1600;
                    ci_value_b_d = {30'd0, ~cur_d.dir_in, cur_d.dir_in};
                end
                S_POLL: begin
                    ci_value_a_d = 32'h0000_1400;
                    ci_value_b_d = '0;
                end
                default: begin
                    ci_value_a_d = '0;
                    ci_value_b_d = '0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and derived status outputs.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        desc_ready_d = (count_d != CNT_W'(DEPTH));
        seq_busy_d   = (state_d != S_IDLE) || (count_d != '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cur_q          <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            gap_cnt_q      <= '0;
            poll_cnt_q     <= '0;
            ci_start_q     <= 1'b0;
            ci_n_q         <= '0;
            ci_value_a_q   <= '0;
            ci_value_b_q   <= '0;
            cmpl_valid_q   <= 1'b0;
            cmpl_error_q   <= 1'b0;
            cmpl_timeout_q <= 1'b0;
            desc_ready_q   <= 1'b1;
            seq_busy_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            gap_cnt_q      <= gap_cnt_d;
            poll_cnt_q     <= poll_cnt_d;
            ci_start_q     <= ci_start_d;
            ci_n_q         <= ci_n_d;
            ci_value_a_q   <= ci_value_a_d;
            ci_value_b_q   <= ci_value_b_d;
            cmpl_valid_q   <= cmpl_valid_d;
            cmpl_error_q   <= cmpl_error_d;
            cmpl_timeout_q <= cmpl_timeout_d;
            desc_ready_q   <= desc_ready_d;
            seq_busy_q     <= seq_busy_d;
        end
    end

    assign bus.descReady   = desc_ready_q;
    assign bus.ciStart     = ci_start_q;
    assign bus.ciN         = ci_n_q;
    assign bus.ciValueA    = ci_value_a_q;
    assign bus.ciValueB    = ci_value_b_q;
    assign bus.cmplValid   = cmpl_valid_q;
    assign bus.cmplError   = cmpl_error_q;
    assign bus.cmplTimeout = cmpl_timeout_q;
    assign bus.seqBusy     = seq_busy_q;
    assign bus.fifoCount   = count_q;

endmodule

// File: tb/tb_dma_ci_sequencer.sv
// Scoreboard bench for dma_ci_sequencer with a DMA CI unit stub.
module tb_dma_ci_sequencer;

    localparam logic [7:0]  CUSTOM_ID  = 8'h5A;
    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned POLL_GAP   = 2;
    localparam int unsigned MAX_POLLS  = 6;

    logic clock = 1'b0;
    logic reset;

    dma_ci_sequencer_if #(.fifoDepthLog2(DEPTH_LOG2)) ifc ();

    dma_ci_sequencer #(
        .customId      (CUSTOM_ID),
        .fifoDepthLog2 (DEPTH_LOG2),
        .pollGap       (POLL_GAP),
        .maxPolls      (16'(MAX_POLLS))
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] bus; logic [8:0] mem; logic [9:0] size; logic [7:0] burst; logic dir; } desc_s;
    typedef struct { int busy; logic err; logic errb; } plan_s;
    typedef struct { logic [31:0] a; logic [31:0] b; } op_s;
    typedef struct { logic err; logic to; } cmpl_s;

    op_s   exp_ops[$];
    cmpl_s exp_cmpl[$];
    plan_s stub_plans[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit saw_full;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // DMA CI unit stub: writes finish in the start cycle, polls one cycle later.
    plan_s       cur_plan;
    int          stub_polls;
    logic        poll_pend;
    logic [31:0] poll_res;

    always @(posedge clock) begin
        if (reset) begin
            poll_pend  <= 1'b0;
            stub_polls <= 0;
        end else begin
            poll_pend <= 1'b0;
            if (ifc.ciStart && ifc.ciValueA == 32'h0000_0600) begin
                if (stub_plans.size() > 0) cur_plan = stub_plans.pop_front();
                else cur_plan = '{busy: 0, err: 1'b0, errb: 1'b0};
                stub_polls <= 0;
            end
            if (ifc.ciStart && ifc.ciValueA == 32'h0000_1400) begin
                poll_pend  <= 1'b1;
                poll_res   <= (stub_polls < cur_plan.busy) ? {30'd0, cur_plan.errb, 1'b1}
                                                            : {30'd0, cur_plan.err, 1'b0};
                stub_polls <= stub_polls + 1;
            end
        end
    end

    assign ifc.ciDone   = (ifc.ciStart && ifc.ciValueA != 32'h0000_1400) || poll_pend;
    assign ifc.ciResult = poll_pend ? poll_res : 32'h0BAD_F00C;

    // Reference model: the CI op list and completion a descriptor must produce.
    task automatic model_add(input desc_s d, input plan_s p);
        int    npolls;
        cmpl_s c;
        if (d.size == 10'd0) begin
            exp_cmpl.push_back('{err: 1'b0, to: 1'b0});
            return;
        end
        stub_plans.push_back(p);
        exp_ops.push_back('{a: 32'h0000_0600, b: d.bus});
        exp_ops.push_back('{a: 32'h0000_0A00, b: {23'd0, d.mem}});
        exp_ops.push_back('{a: 32'h0000_0E00, b: {22'd0, d.size}});
        exp_ops.push_back('{a: 32'h0000_1200, b: {24'd0, d.burst}});
        exp_ops.push_back('{a: 32'h0000_1600, b: {30'd0, ~d.dir, d.dir}});
        npolls = (p.busy >= int'(MAX_POLLS)) ? int'(MAX_POLLS) : p.busy + 1;
        for (int i = 0; i < npolls; i++) exp_ops.push_back('{a: 32'h0000_1400, b: 32'd0});
        c.to  = (p.busy >= int'(MAX_POLLS));
        c.err = c.to ? p.errb : p.err;
        exp_cmpl.push_back(c);
    endtask

    // Monitor: pops expectations whenever the DUT presents a CI op or a completion.
    op_s   got_op;
    cmpl_s got_c;
    int    last_poll_cyc;
    bit    prev_poll;
    logic  last_err, last_to;

    always @(negedge clock) begin
        if (reset) begin
            prev_poll = 1'b0;
            last_err  = 1'b0;
            last_to   = 1'b0;
        end else begin
            if (ifc.ciStart) begin
                if (exp_ops.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ci_op: got A=%h B=%h, expected no CI op (cycle %0d)",
                             ifc.ciValueA, ifc.ciValueB, cyc);
                end else begin
                    got_op = exp_ops.pop_front();
                    check("ci_value_a", 96'(ifc.ciValueA), 96'(got_op.a));
                    check("ci_value_b", 96'(ifc.ciValueB), 96'(got_op.b));
                    check("ci_n", 96'(ifc.ciN), 96'(CUSTOM_ID));
                end
                if (ifc.ciValueA == 32'h0000_1400) begin
                    if (prev_poll) check("poll_spacing", 96'(cyc - last_poll_cyc), 96'(POLL_GAP + 2));
                    prev_poll     = 1'b1;
                    last_poll_cyc = cyc;
                end else begin
                    prev_poll = 1'b0;
                end
            end else begin
                check("ci_idle_zero", 96'({ifc.ciN, ifc.ciValueA, ifc.ciValueB}), 96'd0);
            end
            if (ifc.cmplValid) begin
                if (exp_cmpl.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_cmpl: got err=%b to=%b, expected no completion (cycle %0d)",
                             ifc.cmplError, ifc.cmplTimeout, cyc);
                end else begin
                    got_c = exp_cmpl.pop_front();
                    check("cmpl_flags", 96'({ifc.cmplError, ifc.cmplTimeout}), 96'({got_c.err, got_c.to}));
                end
                last_err  = ifc.cmplError;
                last_to   = ifc.cmplTimeout;
                prev_poll = 1'b0;
            end else begin
                check("cmpl_flags_held", 96'({ifc.cmplError, ifc.cmplTimeout}), 96'({last_err, last_to}));
            end
        end
    end

    // Presents a descriptor (left asserted) until accepted; inputs change #1 after posedge.
    task automatic push_desc(input desc_s d, input plan_s p);
        logic rdy;
        int   guard;
        guard             = 0;
        ifc.descValid     = 1'b1;
        ifc.descBusAddr   = d.bus;
        ifc.descMemAddr   = d.mem;
        ifc.descBlockSize = d.size;
        ifc.descBurstSize = d.burst;
        ifc.descDirIn     = d.dir;
        do begin
            rdy = ifc.descReady;
            if (!rdy && !saw_full) begin
                saw_full = 1'b1;
                check("fifo_count_full", 96'(ifc.fifoCount), 96'(1 << DEPTH_LOG2));
            end
            @(posedge clock); #1;
            guard++;
        end while (!rdy && guard < 2000);
        if (!rdy) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout: descReady stayed 0, required 1 within 2000 cycles");
        end else begin
            model_add(d, p);
        end
    endtask

    task automatic drain(input int limit);
        int guard;
        guard = 0;
        while ((exp_ops.size() != 0 || exp_cmpl.size() != 0 || ifc.seqBusy) && guard < limit) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= limit) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d ops and %0d completions outstanding, required 0",
                     exp_ops.size(), exp_cmpl.size());
        end
    endtask

    function automatic desc_s rand_desc();
        desc_s d;
        d.bus   = $urandom;
        d.mem   = 9'($urandom);
        d.size  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        d.burst = 8'($urandom);
        d.dir   = 1'($urandom);
        return d;
    endfunction

    function automatic plan_s rand_plan();
        plan_s p;
        p.busy = $urandom_range(0, 8);
        p.err  = 1'($urandom);
        p.errb = 1'($urandom);
        return p;
    endfunction

    initial begin
        int guard;
        desc_s d;
        reset             = 1'b1;
        saw_full          = 1'b0;
        ifc.descValid     = 1'b0;
        ifc.descBusAddr   = '0;
        ifc.descMemAddr   = '0;
        ifc.descBlockSize = '0;
        ifc.descBurstSize = '0;
        ifc.descDirIn     = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state.
        check("rst_ci_start", 96'(ifc.ciStart), 96'd0);
        check("rst_cmpl", 96'({ifc.cmplValid, ifc.cmplError, ifc.cmplTimeout}), 96'd0);
        check("rst_fifo_count", 96'(ifc.fifoCount), 96'd0);
        check("rst_desc_ready", 96'(ifc.descReady), 96'd1);
        check("rst_seq_busy", 96'(ifc.seqBusy), 96'd0);
        check("rst_ci_values", 96'({ifc.ciValueA, ifc.ciValueB}), 96'd0);

        // Basic transfer with three busy polls.
        push_desc('{32'h1000_0000, 9'h010, 10'd8, 8'd3, 1'b1}, '{busy: 3, err: 1'b0, errb: 1'b0});
        ifc.descValid = 1'b0;
        drain(500);

        // Bus error on idle status, then a clean descriptor.
        push_desc('{32'h2000_0004, 9'h1FF, 10'd1, 8'd0, 1'b0}, '{busy: 0, err: 1'b1, errb: 1'b0});
        push_desc('{32'h3000_0008, 9'h020, 10'd16, 8'd7, 1'b1}, '{busy: 2, err: 1'b0, errb: 1'b0});
        ifc.descValid = 1'b0;
        drain(500);

        // Poll limit: DMA never goes idle, then the next descriptor is served.
        push_desc('{32'h4000_0000, 9'h001, 10'd1023, 8'd255, 1'b0}, '{busy: 1000, err: 1'b0, errb: 1'b1});
        push_desc('{32'h5000_0010, 9'h002, 10'd2, 8'd1, 1'b1}, '{busy: 0, err: 1'b0, errb: 1'b0});
        ifc.descValid = 1'b0;
        drain(500);

        // Zero-length descriptor completes two cycles after the push with no CI traffic.
        push_desc('{32'h6000_0000, 9'h003, 10'd0, 8'd4, 1'b1}, '{busy: 0, err: 1'b0, errb: 1'b0});
        ifc.descValid = 1'b0;
        check("zero_len_cmpl_early", 96'(ifc.cmplValid), 96'd0);
        @(posedge clock); #1;
        check("zero_len_cmpl_at_2", 96'(ifc.cmplValid), 96'd1);
        drain(100);

        // Back-to-back pushes behind a long transfer fill the FIFO.
        saw_full = 1'b0;
        push_desc('{32'h7000_0000, 9'h004, 10'd5, 8'd2, 1'b0}, '{busy: 5, err: 1'b0, errb: 1'b0});
        for (int i = 0; i < 5; i++) begin
            d      = rand_desc();
            d.size = 10'(i + 1);
            push_desc(d, '{busy: i, err: 1'(i), errb: 1'b0});
        end
        ifc.descValid = 1'b0;
        check("fifo_went_full", 96'(saw_full), 96'd1);
        drain(2000);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            int gap;
            push_desc(rand_desc(), rand_plan());
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                ifc.descValid = 1'b0;
                repeat (gap) @(posedge clock);
                #1;
            end
        end
        ifc.descValid = 1'b0;
        drain(5000);

        // Reset while waiting between KICK and the first poll.
        push_desc('{32'h8000_0000, 9'h005, 10'd4, 8'd1, 1'b1}, '{busy: 3, err: 1'b0, errb: 1'b0});
        ifc.descValid = 1'b0;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(ifc.ciStart && ifc.ciValueA == 32'h0000_1600) && guard < 200);
        check("kick_seen", 96'(ifc.ciStart && ifc.ciValueA == 32'h0000_1600), 96'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        exp_ops.delete();
        exp_cmpl.delete();
        stub_plans.delete();
        @(posedge clock); #1;
        check("rst_mid_ci_start", 96'(ifc.ciStart), 96'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_mid_fifo_count", 96'(ifc.fifoCount), 96'd0);
        check("rst_mid_desc_ready", 96'(ifc.descReady), 96'd1);
        check("rst_mid_cmpl_valid", 96'(ifc.cmplValid), 96'd0);
        check("rst_mid_seq_busy", 96'(ifc.seqBusy), 96'd0);
        repeat (30) @(posedge clock);
        #1;

        // Operation resumes after the abandoned transfer.
        push_desc('{32'h9000_000C, 9'h006, 10'd3, 8'd0, 1'b0}, '{busy: 1, err: 1'b0, errb: 1'b0});
        ifc.descValid = 1'b0;
        drain(500);

        check("queues_empty", 96'(exp_ops.size() + exp_cmpl.size()), 96'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached before the sequence ended");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_ci_sequencer.md
Name: dma_ci_sequencer

Overview:
Hardware front-end that runs DMA transfers through the SRAM/DMA custom-instruction unit without CPU involvement. It accepts transfer descriptors into a small FIFO. For each descriptor it drives the CI port to program bus address, memory address, block size and burst size, starts the DMA, then polls the status register until the DMA goes idle. It reports one completion per descriptor, carrying error and timeout flags. It sits between an accelerator or descriptor source and the DMA CI unit, and owns that unit's CI port.

Parameters:
customId, 8'h00, ciN value driven on every CI operation (must match the DMA unit's id)
fifoDepthLog2, 2, descriptor FIFO depth = 2**fifoDepthLog2
pollGap, 4, idle cycles between consecutive status polls (0 = back-to-back)
maxPolls, 16'd4096, status reads without seeing idle before the transfer is declared timed out

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
descValid  in  1  descriptor present
descReady  out  1  FIFO not full; push occurs when descValid & descReady
descBusAddr  in  32  bus start address (byte address; bits [1:0] passed through unchanged)
descMemAddr  in  9  SRAM start word
descBlockSize  in  10  words to move
descBurstSize  in  8  burst length minus 1
descDirIn  in  1  1 = bus->SRAM, 0 = SRAM->bus
ciStart  out  1  CI start pulse
ciN  out  8  CI number
ciValueA  out  32  CI operand A
ciValueB  out  32  CI operand B
ciDone  in  1  CI done
ciResult  in  32  CI result
cmplValid  out  1  one-cycle completion pulse
cmplError  out  1  bus error reported by DMA (valid with cmplValid)
cmplTimeout  out  1  poll limit hit (valid with cmplValid)
seqBusy  out  1  state != IDLE or FIFO non-empty
fifoCount  out  fifoDepthLog2+1  descriptors queued

Behaviour:
- Reset:
  - state IDLE, FIFO emptied.
  - ciStart, cmplValid, cmplError, cmplTimeout = 0; ciValueA = ciValueB = 0; fifoCount = 0.
  - descReady = 1 from the first cycle after reset deasserts.
- Reset mid-operation: sequence abandoned, no completion is reported, and ciStart is low in the next cycle. The DMA unit itself is not aborted.
- FIFO:
  - Push on descValid & descReady; pop on IDLE->CFG_BUS.
  - Simultaneous push and pop while full is not allowed (descReady = 0 when full, even if a pop occurs the same cycle).
  - Pointers wrap modulo depth.
- ciN = customId whenever ciStart = 1, else 0. ciValueA and ciValueB are 0 when ciStart = 0.
- CI op encodings (valueA / valueB):
  - CFG_BUS: 0x600 / descBusAddr
  - CFG_MEM: 0xA00 / {23'd0, descMemAddr}
  - CFG_SIZE: 0xE00 / {22'd0, descBlockSize}
  - CFG_BURST: 0x1200 / {24'd0, descBurstSize}
  - KICK: 0x1600 / {30'd0, ~dirIn, dirIn}
  - POLL: 0x1400 / 0
- CI handshake:
  - Each op asserts ciStart for exactly one cycle, then waits for ciDone.
  - ciDone is accepted in the same cycle as ciStart (write ops complete that way) or in any later cycle (reads complete one cycle later).
  - For POLL, ciResult is sampled in the ciDone cycle: bit0 = dmaBusy, bit1 = busError.
- FSM:
  - IDLE: if FIFO non-empty, latch head descriptor, pop -> CFG_BUS.
  - CFG_BUS -> CFG_MEM -> CFG_SIZE -> CFG_BURST -> KICK. Each step advances on ciDone.
  - Zero-length descriptor (descBlockSize == 0): skip all CI traffic and go IDLE -> CMPL, with error = 0 and timeout = 0.
  - KICK (done) -> GAP with gapCnt = pollGap; pollCnt cleared.
  - GAP: decrement; at 0 -> POLL. If pollGap = 0, go to POLL directly.
  - POLL (done):
    - busy = 0 -> CMPL, with error = bit1.
    - busy = 1 and pollCnt == maxPolls-1 -> CMPL, with timeout = 1 and error = bit1.
    - otherwise pollCnt++ -> GAP.
  - CMPL: cmplValid = 1 for one cycle with flags -> IDLE.
- Flags are held until the next CMPL and cleared at its start.
- Completion order equals descriptor order.
- Minimum latency, pollGap = 0, DMA idle at first poll: 7 CI cycles from pop to cmplValid (5 single-cycle writes, 1 poll start, 1 poll done), +1 for CMPL.
- Counters:
  - pollCnt is 16 bits and saturates (never wraps).
  - gapCnt width is derived from pollGap.

Test Plan:
1. Push {busAddr 0x1000_0000, mem 0x010, size 8, burst 3, dirIn 1} with a stub that answers writes same-cycle and reports busy for 3 polls -> CI sequence 0x600/0x10000000, 0xA00/0x10, 0xE00/8, 0x1200/3, 0x1600/1, four polls 0x1400; one cmplValid with error 0, timeout 0.
2. Push 4 descriptors back-to-back with depth 4 -> descReady drops after the 4th, fifoCount = 4; completions arrive in order; the fifth push is accepted only after the first pop.
3. Stub returns status 0x2 (error, idle) -> cmplError = 1, cmplTimeout = 0; the next descriptor completes with cmplError = 0.
4. maxPolls = 3, stub always returns busy -> exactly 3 polls, then cmplTimeout = 1; the FSM then serves the next descriptor.
5. descBlockSize = 0 -> no ciStart at all; cmplValid 2 cycles after push.
6. Assert reset during GAP after KICK -> no cmplValid; ciStart = 0, fifoCount = 0, descReady = 1 after reset.
